// File: rtl/fpa_issue_stage.sv
// Issue stage for the FP adder: buffers tagged operand pairs, issues one per cycle, re-tags adder results.
// Latency: pair accepted at edge k issues after k+1; tagged result valid after k+ADD_LAT+2.
// Backpressure: in_ready drops only when the FIFO is full; no output backpressure. Optional FPA_CLASSIFY_EN.
module fpa_issue_stage #(
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              number_A,
  output logic [31:0]              number_B,
  output logic                     issue_valid,
  input  logic [31:0]              number_out,
  output logic                     out_valid,
  output logic [31:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [2:0]               out_class_a,
  output logic [2:0]               out_class_b,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } ent_t;

  // Sideband that travels alongside an issued pair until its result returns.
  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
`ifdef FPA_CLASSIFY_EN
    logic [2:0]       cls_a;
    logic [2:0]       cls_b;
`endif
  } side_t;

`ifdef FPA_CLASSIFY_EN
  // 0 zero, 1 subnormal, 2 normal, 3 inf, 4 NaN; sign is ignored.
  function automatic logic [2:0] fp_class(input logic [31:0] v);
    logic [2:0] c;
    if (v[30:23] == 8'h00)      c = (v[22:0] == 23'd0) ? 3'd0 : 3'd1;
    else if (v[30:23] == 8'hFF) c = (v[22:0] == 23'd0) ? 3'd3 : 3'd4;
    else                        c = 3'd2;
    return c;
  endfunction
`endif

  ent_t                     mem_q [DEPTH];
  ent_t                     mem_d [DEPTH];
  ent_t                     head;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     push, pop;
  logic [31:0]              num_a_q, num_a_d, num_b_q, num_b_d;
  side_t                    iss_q, iss_d;
  side_t [ADD_LAT-1:0]      pipe_q, pipe_d;
  side_t                    out_q, out_d;
  logic [31:0]              res_q, res_d;

  // Full is taken from the registered count only; a same-cycle pop does not reopen the input.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign occupancy = count_q;

  // FIFO storage, pointers and entry count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = '{a: in_a, b: in_b, tag: in_tag};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  // Issue register: pop the head onto the adder inputs, hold operands when idle.
  always_comb begin
    num_a_d   = num_a_q;
    num_b_d   = num_b_q;
    iss_d     = iss_q;
    iss_d.vld = 1'b0;
    if (pop) begin
      num_a_d     = head.a;
      num_b_d     = head.b;
      iss_d.vld   = 1'b1;
      iss_d.tag   = head.tag;
`ifdef FPA_CLASSIFY_EN
      iss_d.cls_a = fp_class(head.a);
      iss_d.cls_b = fp_class(head.b);
`endif
    end
  end

  // Sideband delay line matched to the adder latency.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = iss_q;
    for (int i = 1; i < ADD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Output register: capture the adder result when the delay-line tail is valid.
  always_comb begin
    out_d     = out_q;
    out_d.vld = 1'b0;
    res_d     = res_q;
    if (pipe_q[ADD_LAT-1].vld) begin
      out_d = pipe_q[ADD_LAT-1];
      res_d = number_out;
    end
  end

  // Control and datapath state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      num_a_q  <= '0;
      num_b_q  <= '0;
      iss_q    <= '0;
      pipe_q   <= '0;
      out_q    <= '0;
      res_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      num_a_q  <= num_a_d;
      num_b_q  <= num_b_d;
      iss_q    <= iss_d;
      pipe_q   <= pipe_d;
      out_q    <= out_d;
      res_q    <= res_d;
    end
  end

  // Entry storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign number_A    = num_a_q;
  assign number_B    = num_b_q;
  assign issue_valid = iss_q.vld;
  assign out_valid   = out_q.vld;
  assign out_result  = res_q;
  assign out_tag     = out_q.tag;
`ifdef FPA_CLASSIFY_EN
  assign out_class_a = out_q.cls_a;
  assign out_class_b = out_q.cls_b;
`else
  assign out_class_a = 3'd0;
  assign out_class_b = 3'd0;
`endif

endmodule
